// File: rtl/cache_pkg.sv
// Shared state encoding, requester select and block geometry for the cache fill controller.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WDRAIN,
      DONE,
      STORE
   } fill_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } req_sel_t;

   localparam int BLOCK_WORDS = 8;
   localparam int WORD_IDX_W  = 3;
   localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/fill_arbiter.sv
// Fixed-priority grant among D-miss, store and I-miss, plus the latched owner of the current fill.
module fill_arbiter
   import cache_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     arb_en,
   input  logic     miss_i,
   input  logic     miss_d,
   input  logic     wr_d,
   output logic     grant_miss,
   output logic     grant_store,
   output req_sel_t grant_sel,
   output req_sel_t sel
);

   // D-side misses win so the memory stage is never starved by instruction fetch.
   always_comb begin
      grant_miss  = 1'b0;
      grant_store = 1'b0;
      grant_sel   = REQ_I;
      if (arb_en) begin
         if (miss_d) begin
            grant_miss = 1'b1;
            grant_sel  = REQ_D;
         end else if (wr_d) begin
            grant_store = 1'b1;
         end else if (miss_i) begin
            grant_miss = 1'b1;
            grant_sel  = REQ_I;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel <= REQ_I;
      end else if (grant_miss) begin
         sel <= grant_sel;
      end
   end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/store controller sharing one multi-cycle memory between the I-cache and D-cache.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int MEM_LAT = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              miss_d,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic              wr_d,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy_i,
   output logic              busy_d,
   output logic              done_i,
   output logic              done_d,
   output logic              wr_done,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              fill_we_i,
   output logic              fill_we_d,
   output logic [2:0]        fill_word,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_tag_we_i,
   output logic              fill_tag_we_d,
   output logic [ADDR_W-1:0] fill_base
);

   localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0]     BASE_MASK = ~ADDR_W'(~BLOCK_MASK);

   fill_state_t           state;
   logic [WORD_IDX_W-1:0] iss;
   logic [WORD_IDX_W-1:0] rcv;
   req_sel_t              sel;
   req_sel_t              grant_sel;
   logic                  grant_miss;
   logic                  grant_store;
   logic                  fill_hit;

   if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_check
      $error("cache_fill_ctrl: MEM_LAT must be within 1..8");
   end

   fill_arbiter u_arb (
      .clk         (clk),
      .rst         (rst),
      .arb_en      (state == IDLE),
      .miss_i      (miss_i),
      .miss_d      (miss_d),
      .wr_d        (wr_d),
      .grant_miss  (grant_miss),
      .grant_store (grant_store),
      .grant_sel   (grant_sel),
      .sel         (sel)
   );

   // Returns outside an active fill are stale (e.g. reads in flight across a reset).
   assign fill_hit = mem_valid && (state == FILL || state == WDRAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         iss       <= '0;
         rcv       <= '0;
         fill_base <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_miss) begin
                  fill_base <= ((grant_sel == REQ_D) ? addr_d : addr_i) & BASE_MASK;
                  iss       <= '0;
                  rcv       <= '0;
                  state     <= FILL;
               end else if (grant_store) begin
                  state <= STORE;
               end
            end
            FILL: begin
               iss <= iss + 3'd1;
               if (iss == LAST_WORD) begin
                  state <= WDRAIN;
               end
            end
            WDRAIN: ;
            DONE:    state <= IDLE;
            STORE:   state <= IDLE;
            default: state <= IDLE;
         endcase
         // The last returned word ends the fill regardless of issue progress.
         if (fill_hit) begin
            rcv <= rcv + 3'd1;
            if (rcv == LAST_WORD) begin
               state <= DONE;
            end
         end
      end
   end

   always_comb begin
      mem_en        = 1'b0;
      mem_wr        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      wr_done       = 1'b0;
      done_i        = 1'b0;
      done_d        = 1'b0;
      fill_we_i     = 1'b0;
      fill_we_d     = 1'b0;
      fill_word     = '0;
      fill_data     = '0;
      fill_tag_we_i = 1'b0;
      fill_tag_we_d = 1'b0;
      case (state)
         FILL: begin
            mem_en   = 1'b1;
            mem_addr = fill_base + ADDR_W'({iss, 1'b0});
         end
         STORE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            wr_done   = 1'b1;
         end
         DONE: begin
            done_i = (sel == REQ_I);
            done_d = (sel == REQ_D);
         end
         default: ;
      endcase
      if (fill_hit) begin
         fill_we_i     = (sel == REQ_I);
         fill_we_d     = (sel == REQ_D);
         fill_word     = rcv;
         fill_data     = mem_rdata;
         fill_tag_we_i = (sel == REQ_I) && (rcv == LAST_WORD);
         fill_tag_we_d = (sel == REQ_D) && (rcv == LAST_WORD);
      end
      busy_i = !rst && miss_i && !done_i;
      busy_d = !rst && ((miss_d && !done_d) || (wr_d && !wr_done));
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: per-cycle vector table for one I fill plus multi-cycle corner sequences.
module tb_cache_fill_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_i = 1'b0;
   logic        miss_d = 1'b0;
   logic        wr_d = 1'b0;
   logic [15:0] addr_i = '0;
   logic [15:0] addr_d = '0;
   logic [15:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        busy_i, busy_d, done_i, done_d, wr_done, mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data, fill_base;
   logic        mem_valid, fill_we_i, fill_we_d, fill_tag_we_i, fill_tag_we_d;
   logic [2:0]  fill_word;

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc = 0;
   bit          due [0:4095];
   logic [15:0] dat [0:4095];
   logic        due_now = 1'b0;
   logic [15:0] dat_now = '0;
   logic        inj_valid = 1'b0;

   assign mem_valid = due_now | inj_valid;
   assign mem_rdata = dat_now;

   cache_fill_ctrl #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .miss_i        (miss_i),
      .addr_i        (addr_i),
      .miss_d        (miss_d),
      .addr_d        (addr_d),
      .wr_d          (wr_d),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy_i        (busy_i),
      .busy_d        (busy_d),
      .done_i        (done_i),
      .done_d        (done_d),
      .wr_done       (wr_done),
      .mem_en        (mem_en),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_valid     (mem_valid),
      .fill_we_i     (fill_we_i),
      .fill_we_d     (fill_we_d),
      .fill_word     (fill_word),
      .fill_data     (fill_data),
      .fill_tag_we_i (fill_tag_we_i),
      .fill_tag_we_d (fill_tag_we_d),
      .fill_base     (fill_base)
   );

   always #5 clk = ~clk;

   // Memory model: a read seen mid-cycle c returns 0xA000 + word index during cycle c+LAT.
   always @(negedge clk) begin
      if (!rst && mem_en && !mem_wr) begin
         due[cyc + LAT] = 1'b1;
         dat[cyc + LAT] = 16'hA000 + {13'd0, mem_addr[3:1]};
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      due_now = due[cyc];
      dat_now = due[cyc] ? dat[cyc] : 16'h0;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic        miss;
      logic [15:0] addr;
      logic        en;
      logic [15:0] maddr;
      logic        we;
      logic [2:0]  word;
      logic [15:0] data;
      logic        tag;
      logic        done;
      logic        busy;
   } vec_t;

   vec_t vec [0:14];

   function automatic vec_t mk(input logic miss, input logic [15:0] addr, input logic en,
                               input logic [15:0] maddr, input logic we, input logic [2:0] word,
                               input logic [15:0] data, input logic tag, input logic done,
                               input logic busy);
      vec_t v;
      v = '{miss, addr, en, maddr, we, word, data, tag, done, busy};
      return v;
   endfunction

   function automatic logic [127:0] all_outs();
      return 128'({busy_i, busy_d, done_i, done_d, wr_done, mem_en, mem_wr, fill_we_i, fill_we_d,
                   fill_tag_we_i, fill_tag_we_d, fill_word, mem_addr, mem_wdata, fill_data, fill_base});
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input int n);
      miss_i = 1'b0;
      miss_d = 1'b0;
      wr_d   = 1'b0;
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   initial begin : main
      logic [43:0] act, exp;
      int done_d_at, done_i_at, done1, done2, cnt_we_i, cnt_we_d, cnt_tag, cnt_done, cnt_en;
      int wr_at, wd_at;
      logic [15:0] a1, a15, wdat;
      logic        b10, en15;

      vec[0]  = mk(1, 16'h1234, 0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1);
      vec[1]  = mk(1, 16'h1234, 1, 16'h1230, 0, 3'd0, 16'h0000, 0, 0, 1);
      vec[2]  = mk(1, 16'h1234, 1, 16'h1232, 0, 3'd0, 16'h0000, 0, 0, 1);
      vec[3]  = mk(1, 16'h1234, 1, 16'h1234, 0, 3'd0, 16'h0000, 0, 0, 1);
      vec[4]  = mk(1, 16'h1234, 1, 16'h1236, 0, 3'd0, 16'h0000, 0, 0, 1);
      vec[5]  = mk(1, 16'h1234, 1, 16'h1238, 1, 3'd0, 16'hA000, 0, 0, 1);
      vec[6]  = mk(1, 16'h1234, 1, 16'h123A, 1, 3'd1, 16'hA001, 0, 0, 1);
      vec[7]  = mk(1, 16'h1234, 1, 16'h123C, 1, 3'd2, 16'hA002, 0, 0, 1);
      vec[8]  = mk(1, 16'h1234, 1, 16'h123E, 1, 3'd3, 16'hA003, 0, 0, 1);
      vec[9]  = mk(1, 16'h1234, 0, 16'h0000, 1, 3'd4, 16'hA004, 0, 0, 1);
      vec[10] = mk(1, 16'h1234, 0, 16'h0000, 1, 3'd5, 16'hA005, 0, 0, 1);
      vec[11] = mk(1, 16'h1234, 0, 16'h0000, 1, 3'd6, 16'hA006, 0, 0, 1);
      vec[12] = mk(1, 16'h1234, 0, 16'h0000, 1, 3'd7, 16'hA007, 1, 0, 1);
      vec[13] = mk(1, 16'h1234, 0, 16'h0000, 0, 3'd0, 16'h0000, 0, 1, 0);
      vec[14] = mk(0, 16'h1234, 0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0);

      repeat (2) @(posedge clk);
      #2;
      #1;
      check_output("reset_outputs", all_outs(), 128'h0);
      rst = 1'b0;
      apply_stimulus(2);

      // Single I fill, one row per cycle starting at the accept cycle.
      for (int k = 0; k < 15; k++) begin
         miss_i = vec[k].miss;
         addr_i = vec[k].addr;
         #1;
         act = {mem_en, mem_wr, vec[k].en ? mem_addr : 16'h0, fill_we_i, fill_we_d,
                vec[k].we ? fill_word : 3'd0, vec[k].we ? fill_data : 16'h0,
                fill_tag_we_i, fill_tag_we_d, done_i, done_d, busy_i};
         exp = {vec[k].en, 1'b0, vec[k].maddr, vec[k].we, 1'b0, vec[k].word, vec[k].data,
                vec[k].tag, 1'b0, vec[k].done, 1'b0, vec[k].busy};
         check_output($sformatf("imiss_row%0d", k), 128'(act), 128'(exp));
         next_cycle();
      end
      apply_stimulus(2);

      // Simultaneous I and D misses: D served first, I right after.
      done_d_at = -1; done_i_at = -1; cnt_we_i = 0; cnt_we_d = 0; a1 = '0; a15 = '0;
      miss_i = 1'b1; addr_i = 16'h0040;
      miss_d = 1'b1; addr_d = 16'h8008;
      for (int k = 0; k <= 30; k++) begin
         #1;
         if (done_d && done_d_at < 0) done_d_at = k;
         if (done_i && done_i_at < 0) done_i_at = k;
         if (fill_we_d) cnt_we_d++;
         if (fill_we_i) cnt_we_i++;
         if (k == 1) a1 = mem_addr;
         if (k == 15) a15 = mem_addr;
         next_cycle();
         if (done_d_at >= 0) miss_d = 1'b0;
         if (done_i_at >= 0) miss_i = 1'b0;
      end
      check_output("dual_first_addr", 128'(a1), 128'h8000);
      check_output("dual_done_d_cycle", 128'(done_d_at), 128'(13));
      check_output("dual_i_addr_t15", 128'(a15), 128'h0040);
      check_output("dual_done_i_cycle", 128'(done_i_at), 128'(27));
      check_output("dual_we_d_count", 128'(cnt_we_d), 128'(8));
      check_output("dual_we_i_count", 128'(cnt_we_i), 128'(8));
      apply_stimulus(2);

      // Store from idle: one write cycle, no fill activity.
      wr_d = 1'b1; wr_addr = 16'h0100; wr_data = 16'hBEEF;
      #1;
      check_output("store_idle_busy", 128'({busy_d, mem_en}), 128'(2'b10));
      next_cycle();
      #1;
      check_output("store_write_cycle",
                   128'({mem_en, mem_wr, mem_addr, mem_wdata, wr_done, fill_we_i, fill_we_d, busy_d}),
                   128'({1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0}));
      next_cycle();
      wr_d = 1'b0;
      #1;
      check_output("store_back_idle", 128'({mem_en, wr_done}), 128'(2'b00));
      apply_stimulus(2);

      // Store raised during an I fill is held off until the fill retires.
      done_i_at = -1; wr_at = -1; wd_at = -1; wdat = '0; b10 = 1'b0;
      miss_i = 1'b1; addr_i = 16'h0000;
      for (int k = 0; k <= 20; k++) begin
         if (k == 3) begin
            wr_d = 1'b1; wr_addr = 16'h0200; wr_data = 16'h1234;
         end
         #1;
         if (done_i && done_i_at < 0) done_i_at = k;
         if (mem_en && mem_wr && wr_at < 0) begin
            wr_at = k;
            wdat  = mem_wdata;
         end
         if (wr_done && wd_at < 0) wd_at = k;
         if (k == 10) b10 = busy_d;
         next_cycle();
         if (done_i_at >= 0) miss_i = 1'b0;
         if (wd_at >= 0) wr_d = 1'b0;
      end
      check_output("held_store_write_cycle", 128'(wr_at), 128'(14 + 1));
      check_output("held_store_wr_done", 128'(wd_at), 128'(15));
      check_output("held_store_data", 128'(wdat), 128'h1234);
      check_output("held_store_busy_d", 128'(b10), 128'(1));
      apply_stimulus(2);

      // Reset in the middle of a D fill aborts it; stale returns are ignored.
      cnt_we_d = 0; cnt_tag = 0; cnt_done = 0; cnt_en = 0; a1 = '0;
      miss_d = 1'b1; addr_d = 16'h2000;
      for (int k = 0; k <= 16; k++) begin
         if (k == 6) begin
            rst = 1'b1; miss_d = 1'b0;
         end
         if (k == 7) rst = 1'b0;
         inj_valid = (k >= 7 && k <= 12);
         #1;
         if (k == 5) a1 = fill_base;
         if (k == 6) check_output("rst_mid_fill_all_zero", all_outs(), 128'h0);
         if (k >= 6) begin
            if (fill_we_d) cnt_we_d++;
            if (fill_tag_we_d) cnt_tag++;
            if (done_d) cnt_done++;
            if (mem_en) cnt_en++;
         end
         next_cycle();
      end
      inj_valid = 1'b0;
      check_output("rst_pre_fill_base", 128'(a1), 128'h2000);
      check_output("rst_stale_we_d", 128'(cnt_we_d), 128'(0));
      check_output("rst_stale_tag_done", 128'({cnt_tag[7:0], cnt_done[7:0]}), 128'(0));
      check_output("rst_no_mem_access", 128'(cnt_en), 128'(0));
      apply_stimulus(6);

      // Back-to-back I misses with miss_i held through the first done pulse.
      done1 = -1; done2 = -1; a15 = '0; en15 = 1'b0;
      miss_i = 1'b1; addr_i = 16'h0000;
      for (int k = 0; k <= 30; k++) begin
         #1;
         if (done_i) begin
            if (done1 < 0) done1 = k;
            else if (done2 < 0) done2 = k;
         end
         if (k == 15) begin
            a15  = mem_addr;
            en15 = mem_en;
         end
         next_cycle();
         if (done1 >= 0) addr_i = 16'h0010;
         if (done2 >= 0) miss_i = 1'b0;
      end
      check_output("b2b_first_done", 128'(done1), 128'(13));
      check_output("b2b_second_issue", 128'({en15, a15}), 128'({1'b1, 16'h0010}));
      check_output("b2b_second_done", 128'(done2), 128'(27));
      apply_stimulus(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
